branch_control_unit: RTL and testbench

Sequencing controller for the branch comparator in the RV32I core. It accepts a decoded branch or jump from the pipeline and holds the pipeline while the comparator settles. It drives the comparator's unsigned-select, resolves taken/not-taken from its equal/less-than outputs, and issues PC-select and flush bubbles. It also keeps saturating branch statistics counters.

---
 rtl/branch_control_unit.sv | 132 +++++++++++++
 tb/tb_branch_control_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_control_unit.sv
// rtl/branch_control_unit.sv - RV32I branch comparator sequencer with flush and saturating statistics
module branch_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_branch_valid,
    output logic                 O_branch_ready,
    input  logic [2:0]           I_funct3,
    input  logic                 I_is_jump,
    output logic                 O_branch_unsigned,
    input  logic                 I_branch_equal,
    input  logic                 I_branch_lessthan,
    output logic                 O_stall,
    output logic                 O_resolve_valid,
    output logic                 O_taken,
    output logic                 O_illegal,
    output logic                 O_pc_select,
    output logic                 O_flush,
    input  logic                 I_count_clear,
    output logic [CNT_WIDTH-1:0] O_branch_count,
    output logic [CNT_WIDTH-1:0] O_taken_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_RESOLVE,
        S_FLUSH
    } state_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? FW'(FLUSH_CYCLES - 1) : '0;

    state_t         state_q, state_d;
    logic [2:0]     funct3_q;
    logic           jump_q;
    logic           unsigned_q;
    logic           eq_q, lt_q;
    logic [FW-1:0]  flush_cnt_q;
    logic [CNT_WIDTH-1:0] branch_cnt_q, taken_cnt_q;
    logic           taken_dec, illegal_dec;
    logic           resolve_legal;

    // Decision uses only the registered comparator results, never the live inputs.
    always_comb begin
        taken_dec   = 1'b0;
        illegal_dec = 1'b0;
        if (jump_q) begin
            taken_dec = 1'b1;
        end else begin
            case (funct3_q)
                3'b000:         taken_dec = eq_q;
                3'b001:         taken_dec = ~eq_q;
                3'b100, 3'b110: taken_dec = lt_q;
                3'b101, 3'b111: taken_dec = ~lt_q;
                default:        illegal_dec = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (I_branch_valid) state_d = S_COMPARE;
            S_COMPARE: state_d = S_RESOLVE;
            S_RESOLVE: begin
                if (taken_dec && (FLUSH_CYCLES > 0)) state_d = S_FLUSH;
                else                                 state_d = S_IDLE;
            end
            S_FLUSH:   if (flush_cnt_q == '0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'b000;
            jump_q      <= 1'b0;
            unsigned_q  <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && I_branch_valid) begin
                funct3_q   <= I_funct3;
                jump_q     <= I_is_jump;
                unsigned_q <= I_funct3[1] & ~I_is_jump;
            end
            if (state_q == S_COMPARE) begin
                eq_q <= I_branch_equal;
                lt_q <= I_branch_lessthan;
            end
            if (state_q == S_RESOLVE) begin
                flush_cnt_q <= FLUSH_LAST;
            end else if (state_q == S_FLUSH && flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - 1'b1;
            end
        end
    end

    assign resolve_legal = (state_q == S_RESOLVE) && !illegal_dec;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (I_count_clear) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (resolve_legal) begin
            if (branch_cnt_q != '1)              branch_cnt_q <= branch_cnt_q + 1'b1;
            if (taken_dec && taken_cnt_q != '1)  taken_cnt_q  <= taken_cnt_q + 1'b1;
        end
    end

    assign O_branch_ready    = (state_q == S_IDLE);
    assign O_stall           = (state_q == S_COMPARE) || (state_q == S_RESOLVE);
    assign O_resolve_valid   = (state_q == S_RESOLVE);
    assign O_taken           = (state_q == S_RESOLVE) && taken_dec;
    assign O_illegal         = (state_q == S_RESOLVE) && illegal_dec;
    assign O_pc_select       = (state_q == S_RESOLVE) && taken_dec;
    assign O_flush           = (state_q == S_FLUSH);
    assign O_branch_unsigned = unsigned_q;
    assign O_branch_count    = branch_cnt_q;
    assign O_taken_count     = taken_cnt_q;

endmodule

// File: tb/tb_branch_control_unit.sv
// tb/tb_branch_control_unit.sv - directed self-checking bench for branch_control_unit
module tb_branch_control_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        is_jump = 1'b0;
    logic        branch_equal = 1'b0;
    logic        branch_lessthan = 1'b0;
    logic        count_clear = 1'b0;

    logic        branch_ready, branch_unsigned, stall, resolve_valid, taken, illegal, pc_select, flush;
    logic [15:0] branch_count, taken_count;

    logic        s_ready, s_unsigned, s_stall, s_rv, s_taken, s_illegal, s_pcsel, s_flush;
    logic [1:0]  s_branch_count, s_taken_count;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] m_bc, m_tc;
    logic [1:0]  m_sbc, m_stc;

    always #5 clk = ~clk;

    branch_control_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_branch_valid(branch_valid), .O_branch_ready(branch_ready),
        .I_funct3(funct3), .I_is_jump(is_jump), .O_branch_unsigned(branch_unsigned),
        .I_branch_equal(branch_equal), .I_branch_lessthan(branch_lessthan), .O_stall(stall),
        .O_resolve_valid(resolve_valid), .O_taken(taken), .O_illegal(illegal), .O_pc_select(pc_select),
        .O_flush(flush), .I_count_clear(count_clear), .O_branch_count(branch_count),
        .O_taken_count(taken_count)
    );

    branch_control_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(2)) dut_sat (
        .I_clk(clk), .I_rst_n(rst_n), .I_branch_valid(branch_valid), .O_branch_ready(s_ready),
        .I_funct3(funct3), .I_is_jump(is_jump), .O_branch_unsigned(s_unsigned),
        .I_branch_equal(branch_equal), .I_branch_lessthan(branch_lessthan), .O_stall(s_stall),
        .O_resolve_valid(s_rv), .O_taken(s_taken), .O_illegal(s_illegal), .O_pc_select(s_pcsel),
        .O_flush(s_flush), .I_count_clear(count_clear), .O_branch_count(s_branch_count),
        .O_taken_count(s_taken_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered just after a negedge with both DUTs idle; returns just after a negedge, idle again.
    task automatic do_branch(input string tag, input logic [2:0] f3, input logic j,
                             input logic eq, input logic lt, input logic hold, input logic clr,
                             input logic e_taken, input logic e_ill, input logic e_uns);
        branch_valid = 1'b1;
        funct3       = f3;
        is_jump      = j;
        @(posedge clk); #1;
        if (!hold) branch_valid = 1'b0;
        branch_equal    = eq;
        branch_lessthan = lt;
        @(negedge clk);
        chk({tag, ".c1_stall"}, stall, 1'b1);
        chk({tag, ".c1_ready"}, branch_ready, 1'b0);
        chk({tag, ".c1_unsigned"}, branch_unsigned, e_uns);
        chk({tag, ".c1_resolve"}, resolve_valid, 1'b0);
        @(posedge clk); #1;
        branch_valid    = 1'b0;
        branch_equal    = ~eq;
        branch_lessthan = ~lt;
        count_clear     = clr;
        @(negedge clk);
        chk({tag, ".c2_resolve"}, resolve_valid, 1'b1);
        chk({tag, ".c2_taken"}, taken, e_taken);
        chk({tag, ".c2_illegal"}, illegal, e_ill);
        chk({tag, ".c2_pcsel"}, pc_select, e_taken);
        chk({tag, ".c2_stall"}, stall, 1'b1);
        @(posedge clk); #1;
        count_clear = 1'b0;
        if (clr) begin
            m_bc = '0; m_tc = '0; m_sbc = '0; m_stc = '0;
        end else if (!e_ill) begin
            if (m_bc != 16'hffff) m_bc++;
            if (m_sbc != 2'b11) m_sbc++;
            if (e_taken) begin
                if (m_tc != 16'hffff) m_tc++;
                if (m_stc != 2'b11) m_stc++;
            end
        end
        @(negedge clk);
        if (e_taken) begin
            for (int i = 0; i < FC; i++) begin
                chk({tag, ".flush"}, flush, 1'b1);
                chk({tag, ".flush_stall"}, stall, 1'b0);
                chk({tag, ".flush_ready"}, branch_ready, 1'b0);
                @(negedge clk);
            end
        end
        chk({tag, ".end_ready"}, branch_ready, 1'b1);
        chk({tag, ".end_flush"}, flush, 1'b0);
        chk({tag, ".end_resolve"}, resolve_valid, 1'b0);
        chk({tag, ".bc"}, branch_count, m_bc);
        chk({tag, ".tc"}, taken_count, m_tc);
        chk({tag, ".sat_bc"}, s_branch_count, m_sbc);
        chk({tag, ".sat_tc"}, s_taken_count, m_stc);
    endtask

    initial begin
        m_bc = '0; m_tc = '0; m_sbc = '0; m_stc = '0;
        repeat (2) @(negedge clk);
        chk("rst.ready", branch_ready, 1'b1);
        chk("rst.stall", stall, 1'b0);
        chk("rst.flush", flush, 1'b0);
        chk("rst.resolve", resolve_valid, 1'b0);
        chk("rst.unsigned", branch_unsigned, 1'b0);
        chk("rst.bc", branch_count, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_branch("beq_t",   3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("beq_t.bc_one", branch_count, 16'd1);
        chk("beq_t.tc_one", taken_count, 16'd1);
        do_branch("bltu_nt", 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bltu_nt.unsigned_hold", branch_unsigned, 1'b1);
        do_branch("bge_nt",  3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_branch("bne_t",   3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_branch("jal",     3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_branch("blt_t",   3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_branch("bgeu_t",  3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_branch("ill010",  3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        do_branch("ill011",  3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        count_clear = 1'b1;
        @(posedge clk); #1;
        count_clear = 1'b0;
        m_bc = '0; m_tc = '0; m_sbc = '0; m_stc = '0;
        @(negedge clk);
        chk("clr_idle.bc", branch_count, 16'd0);
        chk("clr_idle.sat_tc", s_taken_count, 2'd0);
        for (int k = 0; k < 5; k++)
            do_branch("sat_beq", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat.bc3", s_branch_count, 2'd3);
        chk("sat.tc3", s_taken_count, 2'd3);
        chk("sat.main_bc5", branch_count, 16'd5);
        do_branch("clr_res", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        branch_valid = 1'b1; funct3 = 3'b000; is_jump = 1'b0;
        @(posedge clk); #1;
        branch_valid = 1'b0; branch_equal = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_bc++; m_tc++;
        @(negedge clk);
        chk("rstmid.flush_before", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.flush", flush, 1'b0);
        chk("rstmid.ready", branch_ready, 1'b1);
        chk("rstmid.bc", branch_count, 16'd0);
        m_bc = '0; m_tc = '0; m_sbc = '0; m_stc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_branch("post_rst", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
